// File: rtl/enc_pkg.sv
// Shared constants for the quadrature encoder emulator: FSM encoding,
// phase-to-AB lookup and default widths.
package enc_pkg;

    localparam int unsigned CNT_W         = 32;
    localparam int unsigned PER_W         = 16;
    localparam int unsigned EDGES_PER_REV = 400;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // AB pattern per quadrature phase; consecutive entries differ in one bit
    localparam logic [1:0] AB_PH0 = 2'b00;
    localparam logic [1:0] AB_PH1 = 2'b10;
    localparam logic [1:0] AB_PH2 = 2'b11;
    localparam logic [1:0] AB_PH3 = 2'b01;

    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = AB_PH0;
            2'd1:    ab = AB_PH1;
            2'd2:    ab = AB_PH2;
            default: ab = AB_PH3;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Host command / encoder output bundle for the quadrature encoder emulator.
interface quad_encoder_emulator_if #(
    parameter int unsigned CNT_W = enc_pkg::CNT_W,
    parameter int unsigned PER_W = enc_pkg::PER_W
);
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             dir;
    logic [PER_W-1:0] period;
    logic             stop;
    logic             ready;
    logic             done;
    logic             enc_a;
    logic             enc_b;
    logic             enc_z;
    logic [CNT_W-1:0] pos;

    modport master (
        output start, steps, dir, period, stop,
        input  ready, done, enc_a, enc_b, enc_z, pos
    );

    modport slave (
        input  start, steps, dir, period, stop,
        output ready, done, enc_a, enc_b, enc_z, pos
    );
endinterface

// File: rtl/enc_step_timer.sv
// Reloadable down-counter pacing quadrature edges; tick_c marks the last
// cycle of each edge period.
module enc_step_timer #(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [PER_W-1:0] value_i,
    input  logic             run_i,
    output logic             tick_c
);
    logic [PER_W-1:0] timer_q, timer_d;

    assign tick_c = run_i && (timer_q == PER_W'(1));

    always_comb begin
        timer_d = timer_q;
        if (load_i || tick_c) begin
            timer_d = value_i;
        end else if (run_i) begin
            timer_d = timer_q - PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns a host move command into paced A/B/Z
// edges and tracks the emitted position for loopback comparison.
module quad_encoder_emulator #(
    parameter int unsigned CNT_W         = enc_pkg::CNT_W,
    parameter int unsigned PER_W         = enc_pkg::PER_W,
    parameter int unsigned EDGES_PER_REV = enc_pkg::EDGES_PER_REV
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_encoder_emulator_if.slave bus
);
    import enc_pkg::*;

    localparam int unsigned      REV_W    = (EDGES_PER_REV > 1) ? $clog2(EDGES_PER_REV) : 1;
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(EDGES_PER_REV - 1);

    logic [0:0]       state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic [1:0]       phase_q, phase_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             enc_a_q, enc_a_d;
    logic             enc_b_q, enc_b_d;
    logic             enc_z_q, enc_z_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic             tick_c;
    logic [PER_W-1:0] per_eff_c;
    logic [PER_W-1:0] timer_val_c;
    logic [1:0]       phase_nx_c;
    logic [REV_W-1:0] rev_nx_c;
    logic [CNT_W-1:0] pos_nx_c;
    logic [1:0]       ab_nx_c;

    assign accept_c    = (state_q == ST_IDLE) && bus.start && ready_q && (bus.steps != '0);
    assign per_eff_c   = (bus.period == '0) ? PER_W'(1) : bus.period;
    assign timer_val_c = accept_c ? per_eff_c : per_q;
    assign phase_nx_c  = dir_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
    assign pos_nx_c    = dir_q ? (pos_q - CNT_W'(1)) : (pos_q + CNT_W'(1));
    assign ab_nx_c     = phase_to_ab(phase_nx_c);

    // Revolution index wraps at EDGES_PER_REV in both directions
    always_comb begin
        rev_nx_c = rev_q + REV_W'(1);
        if (dir_q) begin
            rev_nx_c = (rev_q == '0) ? REV_LAST : (rev_q - REV_W'(1));
        end else if (rev_q == REV_LAST) begin
            rev_nx_c = '0;
        end
    end

    enc_step_timer #(.PER_W(PER_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept_c),
        .value_i (timer_val_c),
        .run_i   (state_q == ST_RUN),
        .tick_c  (tick_c)
    );

    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        rev_d       = rev_q;
        pos_d       = pos_q;
        enc_a_d     = enc_a_q;
        enc_b_d     = enc_b_q;
        enc_z_d     = enc_z_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d     = ST_RUN;
                    remaining_d = bus.steps;
                    dir_d       = bus.dir;
                    per_d       = per_eff_c;
                    ready_d     = 1'b0;
                end else if (bus.start && ready_q) begin
                    done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort beats a coincident pending edge
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else if (tick_c) begin
                    phase_d     = phase_nx_c;
                    rev_d       = rev_nx_c;
                    pos_d       = pos_nx_c;
                    {enc_a_d, enc_b_d} = ab_nx_c;
                    enc_z_d     = (rev_nx_c == '0) && (phase_nx_c == 2'd0);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            per_q       <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            phase_q     <= 2'd0;
            rev_q       <= '0;
            pos_q       <= '0;
            enc_a_q     <= 1'b0;
            enc_b_q     <= 1'b0;
            enc_z_q     <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            rev_q       <= rev_d;
            pos_q       <= pos_d;
            enc_a_q     <= enc_a_d;
            enc_b_q     <= enc_b_d;
            enc_z_q     <= enc_z_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.enc_a = enc_a_q;
    assign bus.enc_b = enc_b_q;
    assign bus.enc_z = enc_z_q;
    assign bus.pos   = pos_q;
endmodule

// File: doc/quad_encoder_emulator.md
Name: quad_encoder_emulator

Overview:
Generates quadrature encoder signals (A, B, index Z) from a host move command: a step count, a direction and an edge period. It is the transmit side of the encoder path. It drives the same A/B/Z lines that the decoder plus reversibleCounter chain consumes, so it serves both as a motor-feedback emulator and as a loopback stimulus source. An internal position register tracks the emitted edges so loopback results can be compared directly against the counter's `cnt`.

Parameters:
- CNT_W, 32, width of step count and position (matches the counter's `cnt` width).
- PER_W, 16, width of the edge-period field.
- EDGES_PER_REV, 400, quadrature edges per revolution (4 × 100 lines); sets the index spacing.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  move request; accepted when start=1 and ready=1.
- steps  in  CNT_W  number of quadrature edges to emit (unsigned).
- dir  in  1  0 = forward (A leads B), 1 = reverse.
- period  in  PER_W  clocks per edge; 0 is treated as 1.
- stop  in  1  abort the current move.
- ready  out  1  idle, able to accept start.
- done  out  1  one-cycle pulse at move completion or abort.
- enc_a  out  1  quadrature channel A.
- enc_b  out  1  quadrature channel B.
- enc_z  out  1  index; high at phase 0 of revolution position 0.
- pos  out  CNT_W  emitted position, two's-complement, wraps.

Behaviour:
- All outputs are registered.
- Reset values: enc_a=0, enc_b=0, enc_z=1, pos=0, ready=1, done=0. Internal state: IDLE, phase=0, rev_idx=0, timer=0, remaining=0.
- Reset asserted mid-move returns everything to reset values on the next edge. No completion pulse is produced.
- States: IDLE and RUN.
- IDLE→RUN: on start & ready & steps≠0. The block latches steps into remaining, latches dir, and latches max(period,1) into both per_q and timer. ready goes to 0.
- IDLE with start & steps=0: the block stays in IDLE, done=1 for the next cycle, and no edge is emitted.
- RUN, timer countdown: each cycle timer decrements. When timer==1, the next clock emits one edge and reloads timer from per_q. The first edge therefore appears per_q cycles after the accept edge, and consecutive edges are per_q cycles apart.
- Edge, phase: phase advances +1 mod 4 (dir=0) or −1 mod 4 (dir=1).
- Edge, A/B encoding: phase 0/1/2/3 maps to AB = 00/10/11/01.
- Edge, counters: pos ±1 mod 2^CNT_W. rev_idx ±1 mod EDGES_PER_REV, where −1 from 0 wraps to EDGES_PER_REV−1. remaining decrements.
- Index: enc_z = (rev_idx==0 && phase==0). It is registered and updated in the same cycle as A/B.
- Last edge (remaining==1 at the edge): in the same clock the state goes to IDLE, done=1 and ready=1. done is visible in the same cycle as the final A/B value. done is high for exactly one cycle.
- stop in RUN: the next clock goes to IDLE with done=1 and ready=1, and no edge is emitted that clock. If stop coincides with a pending edge, stop wins. A/B/Z/pos hold their values.
- stop in IDLE is ignored. start while in RUN is ignored (ready=0).
- Only one A/B bit changes per edge; a glitch-free Gray sequence is guaranteed.
- Changing period, dir or steps during RUN has no effect; the values latched at accept are used.

Decomposition:
- Package enc_pkg holds:
  - the state encoding (IDLE, RUN);
  - the phase→AB lookup constants (2'b00, 2'b10, 2'b11, 2'b01);
  - the default widths CNT_W and PER_W.
- Sub-module enc_step_timer (PER_W-wide reloadable down-counter):
  - inputs: load, value, run;
  - output: tick, asserted on the cycle timer==1.
- The top level keeps the FSM, the phase/rev_idx/pos registers and the Z decode.

Test Plan:
- Reset: hold rst for 3 cycles → enc_a=0, enc_b=0, enc_z=1, pos=0, ready=1, done=0.
- Forward move (start, steps=8, dir=0, period=4): edges occur 4, 8, …, 32 cycles after accept.
  - AB sequence is 10, 11, 01, 00, 10, 11, 01, 00 and pos=8.
  - done is high for one cycle with the last edge, and ready=1 in that cycle.
  - With EDGES_PER_REV overridden to 8, enc_z pulses only at the final 00.
- Reverse move with wrap (from reset; steps=3, dir=1, period=0): one edge per cycle.
  - AB sequence is 01, 11, 10 and pos=32'hFFFF_FFFD.
  - rev_idx = EDGES_PER_REV−3, so enc_z=0.
- Zero-length move (steps=0): done pulses on the next cycle, AB is unchanged and ready stays 1.
- Abort and ignored start (steps=10, period=2):
  - assert stop on the cycle a 3rd edge is pending → exactly 2 edges are emitted, pos=2, done pulses and AB holds at 11;
  - a start pulse issued mid-move is ignored, with no change to remaining.
- Reset mid-move and loopback:
  - assert rst after 5 of 20 edges → reset values on the next cycle;
  - drive the decoder + reversibleCounter from enc_a/enc_b with 100 random moves → the counter's `cnt` equals pos after each done.
